rst_gen: RTL and testbench
==========================

RST_GEN -- requirements
Module: rst_gen

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of button synchronizer flops (minimum 2).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000, cycles the button must stay pressed before it is accepted.
REQ-003 SHALL have parameter HOLD_CYCLES, default 16, cycles core_rst stays high after a release or power-up.
REQ-004 SHALL have parameter CNT_WIDTH, default 16, counter width, sized to hold the largest cycle parameter.
REQ-005 SHALL have parameter BTN_ACTIVE_LOW, default 1, where 1 means btn_in low = pressed.
REQ-006 SHALL have port clk, input, 1 bit: the divided system clock; this is the block's only clock.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port btn_in, input, 1 bit: raw, asynchronous reset pushbutton.
REQ-009 SHALL have port core_rst, output, 1 bit: active-high reset to the 8051 core.
REQ-010 SHALL have port rst_done, output, 1 bit: one-cycle pulse when core_rst deasserts.
REQ-011 SHALL have port wdt_kick, input, 1 bit: watchdog service strobe (only with RST_GEN_WDT_EN).
REQ-012 SHALL have port wdt_flag, output, 1 bit: sticky flag meaning a watchdog timeout occurred (only with RST_GEN_WDT_EN).

Function
REQ-013 SHALL pass btn_in through SYNC_STAGES flops, then normalise polarity per BTN_ACTIVE_LOW, giving btn_sync (1 = pressed).
REQ-014 SHALL implement an FSM with four states: S_HOLD, S_RUN, S_DEBOUNCE, S_PRESSED.
REQ-015 S_HOLD: cnt increments each cycle; btn_sync=1 clears cnt to 0 (extends hold); cnt==HOLD_CYCLES-1 -> S_RUN with cnt=0.
REQ-016 S_RUN: btn_sync=1 -> S_DEBOUNCE with cnt=0.
REQ-017 S_DEBOUNCE: btn_sync=0 -> S_RUN (glitch rejected); otherwise cnt increments; cnt==DEBOUNCE_CYCLES-1 with btn_sync=1 -> S_PRESSED.
REQ-018 S_PRESSED: remains until btn_sync=0, then -> S_HOLD with cnt=0.
REQ-019 core_rst SHALL be 1 exactly when the state is S_HOLD or S_PRESSED, decoded from registered state only, with no combinational path from any input.
REQ-020 rst_done SHALL pulse high for exactly one cycle, on the first cycle in S_RUN after leaving S_HOLD.
REQ-021 A press held continuously SHALL raise core_rst SYNC_STAGES+DEBOUNCE_CYCLES edges after the first edge that samples it pressed.
REQ-022 Counter arithmetic SHALL be unsigned CNT_WIDTH bits and SHALL never wrap; every counting state exits or clears before reaching the terminal value plus one.
REQ-023 A press and a release in the same cycle cannot occur; btn_sync SHALL be the only button input to the FSM.

Reset
REQ-024 rst=1 SHALL, at the next clk edge, set state=S_HOLD, cnt=0, all synchronizer flops to the not-pressed level, rst_done=0 and wdt_flag=0.
REQ-025 core_rst SHALL be 1 during reset and through the HOLD_CYCLES that follow, including when rst is asserted mid-debounce or mid-press.

Configuration
REQ-026 Macro RST_GEN_WDT_EN defined: a CNT_WIDTH watchdog counter (parameter WDT_CYCLES, default 4096) runs only in S_RUN.
REQ-027 With RST_GEN_WDT_EN, wdt_kick=1 clears the watchdog counter.
REQ-028 With RST_GEN_WDT_EN, reaching WDT_CYCLES-1 forces S_HOLD with cnt=0 and sets wdt_flag; wdt_flag clears only on rst.
REQ-029 Macro RST_GEN_WDT_EN undefined: wdt_kick, wdt_flag, WDT_CYCLES and the watchdog logic SHALL be absent, and behaviour is otherwise identical.

Structure
REQ-030 Package rst_gen_pkg SHALL hold the state encoding constants (2-bit, S_HOLD=0, S_RUN=1, S_DEBOUNCE=2, S_PRESSED=3) and the parameter defaults.
REQ-031 The synchronizer SHALL be sub-module rst_gen_sync (parameter STAGES, configurable reset level); the FSM and counters stay in rst_gen.

Verification
Bench parameters: SYNC_STAGES=2, DEBOUNCE_CYCLES=8, HOLD_CYCLES=4, WDT_CYCLES=16.
REQ-032 Release rst -> core_rst=1 for 4 cycles, then 0, with rst_done=1 for exactly 1 cycle.
REQ-033 btn_in low for 3 cycles, then high -> core_rst stays 0 throughout and the FSM returns to S_RUN.
REQ-034 btn_in low for 30 cycles -> core_rst rises 10 edges after the first sampled-low edge and stays 1 until release.
REQ-035 Release then re-press after 2 cycles -> hold restarts; core_rst stays 1 until 4 consecutive unpressed cycles, then falls with one rst_done pulse.
REQ-036 rst asserted in S_DEBOUNCE at cnt=5 -> next cycle state=S_HOLD and core_rst=1, followed by a full 4-cycle hold.
REQ-037 With RST_GEN_WDT_EN and no kick for 16 cycles in S_RUN -> core_rst=1 and wdt_flag=1; kicking every 10 cycles -> no timeout.

Source files
------------

// File: rtl/rst_gen_pkg.sv
// rst_gen_pkg: FSM state encoding and parameter defaults for the rst_gen
// reset generator. The optional watchdog is enabled by defining RST_GEN_WDT_EN.
package rst_gen_pkg;

   // Reset generator states, 2-bit encoding fixed so other blocks can decode it
   typedef enum logic [1:0] {
      S_HOLD     = 2'd0,
      S_RUN      = 2'd1,
      S_DEBOUNCE = 2'd2,
      S_PRESSED  = 2'd3
   } state_e;

   localparam int SYNC_STAGES_DEF     = 2;
   localparam int DEBOUNCE_CYCLES_DEF = 1000;
   localparam int HOLD_CYCLES_DEF     = 16;
   localparam int CNT_WIDTH_DEF       = 16;
   localparam int BTN_ACTIVE_LOW_DEF  = 1;
   localparam int WDT_CYCLES_DEF      = 4096;

   // True for the states in which the core must be held in reset
   function automatic logic is_rst_state(input state_e s);
      logic r;
      if ((s == S_HOLD) || (s == S_PRESSED)) begin
         r = 1'b1;
      end else begin
         r = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/rst_gen_sync.sv
// rst_gen_sync: STAGES-deep flop chain bringing an asynchronous level into
// the clk domain. The reset level is configurable so the chain can come out
// of reset at the input's inactive level.
module rst_gen_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
)(
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_r;

   // Shift the raw input through the chain; reset loads the idle level
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_r <= {STAGES{RST_VAL}};
      end else begin
         sync_r <= {sync_r[STAGES-2:0], d};
      end
   end

   assign q = sync_r[STAGES-1];

endmodule

// File: rtl/rst_gen.sv
// rst_gen: 8051 core reset generator. Synchronises and debounces a reset
// pushbutton, stretches every reset by HOLD_CYCLES and pulses rst_done when
// the core is released. Defining RST_GEN_WDT_EN adds a watchdog that forces
// a reset when wdt_kick is not seen for WDT_CYCLES cycles in S_RUN.
module rst_gen
   import rst_gen_pkg::*;
#(
   parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF,
   parameter int CNT_WIDTH       = CNT_WIDTH_DEF,
   parameter int BTN_ACTIVE_LOW  = BTN_ACTIVE_LOW_DEF
`ifdef RST_GEN_WDT_EN
   ,
   parameter int WDT_CYCLES      = WDT_CYCLES_DEF
`endif
)(
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
`ifdef RST_GEN_WDT_EN
   input  logic wdt_kick,
   output logic wdt_flag,
`endif
   output logic core_rst,
   output logic rst_done
);

   localparam logic                 IDLE_LVL  = (BTN_ACTIVE_LOW != 0);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] DEB_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   state_e               state_r;
   state_e               state_nxt_s;
   logic [CNT_WIDTH-1:0] cnt_r;
   logic [CNT_WIDTH-1:0] cnt_nxt_s;
   logic                 btn_raw_s;
   logic                 btn_sync_s;
   logic                 wdt_expire_s;
   logic                 core_rst_r;
   logic                 rst_done_r;

   rst_gen_sync #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (IDLE_LVL)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (btn_in),
      .q   (btn_raw_s)
   );

   // Normalise polarity: btn_sync_s is 1 while the button is pressed
   assign btn_sync_s = (BTN_ACTIVE_LOW != 0) ? ~btn_raw_s : btn_raw_s;

`ifdef RST_GEN_WDT_EN
   localparam logic [CNT_WIDTH-1:0] WDT_LAST = CNT_WIDTH'(WDT_CYCLES - 1);

   logic [CNT_WIDTH-1:0] wdt_cnt_r;
   logic                 wdt_flag_r;

   assign wdt_expire_s = (state_r == S_RUN) && !wdt_kick && (wdt_cnt_r == WDT_LAST);

   // Watchdog counter: counts only in S_RUN, cleared by a kick or on expiry
   always_ff @(posedge clk) begin
      if (rst) begin
         wdt_cnt_r <= '0;
      end else if ((state_r != S_RUN) || wdt_kick || wdt_expire_s) begin
         wdt_cnt_r <= '0;
      end else begin
         wdt_cnt_r <= wdt_cnt_r + CNT_ONE;
      end
   end

   // Sticky timeout flag, cleared only by rst
   always_ff @(posedge clk) begin
      if (rst) begin
         wdt_flag_r <= 1'b0;
      end else if (wdt_expire_s) begin
         wdt_flag_r <= 1'b1;
      end else begin
         wdt_flag_r <= wdt_flag_r;
      end
   end

   assign wdt_flag = wdt_flag_r;
`else
   assign wdt_expire_s = 1'b0;
`endif

   // State and shared cycle counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_HOLD;
         cnt_r   <= '0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Next-state and counter logic; every counting state leaves or clears at its terminal value
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         S_HOLD: begin
            if (btn_sync_s) begin
               cnt_nxt_s = '0;
            end else if (cnt_r == HOLD_LAST) begin
               state_nxt_s = S_RUN;
               cnt_nxt_s   = '0;
            end else begin
               cnt_nxt_s = cnt_r + CNT_ONE;
            end
         end
         S_RUN: begin
            if (wdt_expire_s) begin
               state_nxt_s = S_HOLD;
               cnt_nxt_s   = '0;
            end else if (btn_sync_s) begin
               state_nxt_s = S_DEBOUNCE;
               cnt_nxt_s   = '0;
            end else begin
               cnt_nxt_s = '0;
            end
         end
         S_DEBOUNCE: begin
            if (!btn_sync_s) begin
               state_nxt_s = S_RUN;
               cnt_nxt_s   = '0;
            end else if (cnt_r == DEB_LAST) begin
               state_nxt_s = S_PRESSED;
               cnt_nxt_s   = '0;
            end else begin
               cnt_nxt_s = cnt_r + CNT_ONE;
            end
         end
         S_PRESSED: begin
            if (!btn_sync_s) begin
               state_nxt_s = S_HOLD;
               cnt_nxt_s   = '0;
            end else begin
               cnt_nxt_s = '0;
            end
         end
         default: begin
            state_nxt_s = S_HOLD;
            cnt_nxt_s   = '0;
         end
      endcase
   end

   // Registered outputs: core_rst tracks the state decode without decode glitches,
   // rst_done marks the first S_RUN cycle after a hold
   always_ff @(posedge clk) begin
      if (rst) begin
         core_rst_r <= 1'b1;
         rst_done_r <= 1'b0;
      end else begin
         core_rst_r <= is_rst_state(state_nxt_s);
         rst_done_r <= (state_r == S_HOLD) && (state_nxt_s == S_RUN);
      end
   end

   assign core_rst = core_rst_r;
   assign rst_done = rst_done_r;

endmodule

// File: tb/tb_rst_gen.sv
// tb_rst_gen: self-checking bench for rst_gen (SYNC_STAGES=2, DEBOUNCE_CYCLES=8,
// HOLD_CYCLES=4, WDT_CYCLES=16). Directed scenarios followed by random button,
// reset and kick traffic, all compared against a behavioural reference model.
// Build with RST_GEN_WDT_EN defined to cover the watchdog as well.
module tb_rst_gen;
   import rst_gen_pkg::*;

   localparam int SYNC = 2;
   localparam int DEB  = 8;
   localparam int HOLD = 4;
   localparam int WDT  = 16;

   // Reference model modes (not the DUT encoding)
   localparam int M_HOLDING = 0;
   localparam int M_RUNNING = 1;
   localparam int M_LATCHED = 2;

   logic clk = 1'b0;
   logic rst;
   logic btn_in;
   logic core_rst;
   logic rst_done;
`ifdef RST_GEN_WDT_EN
   logic wdt_kick;
   logic wdt_flag;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // model state
   int   m_mode;
   int   m_quiet;   // consecutive unpressed edges since the hold (re)started
   int   m_streak;  // consecutive pressed edges seen while running
   int   m_idle;    // consecutive unkicked edges in the idle running state
   logic m_flag;
   logic m_done;
   logic m_hist [SYNC];

   always #5 clk = ~clk;

   rst_gen #(
      .SYNC_STAGES     (SYNC),
      .DEBOUNCE_CYCLES (DEB),
      .HOLD_CYCLES     (HOLD),
      .CNT_WIDTH       (16),
      .BTN_ACTIVE_LOW  (1)
`ifdef RST_GEN_WDT_EN
      ,
      .WDT_CYCLES      (WDT)
`endif
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_in   (btn_in),
`ifdef RST_GEN_WDT_EN
      .wdt_kick (wdt_kick),
      .wdt_flag (wdt_flag),
`endif
      .core_rst (core_rst),
      .rst_done (rst_done)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Advance the reference model by one clock edge
   task automatic model_edge(input logic r, input logic b, input logic k);
      logic p;
      logic timeout;
      if (r) begin
         m_mode   = M_HOLDING;
         m_quiet  = 0;
         m_streak = 0;
         m_idle   = 0;
         m_flag   = 1'b0;
         m_done   = 1'b0;
         for (int i = 0; i < SYNC; i++) m_hist[i] = 1'b0;
         return;
      end
      // press seen by the controller is the sample taken SYNC edges ago
      p = m_hist[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = ~b;
      m_done  = 1'b0;
      timeout = 1'b0;
      if (m_mode == M_HOLDING) begin
         m_idle = 0;
         if (p) begin
            m_quiet = 0;
         end else begin
            m_quiet++;
            if (m_quiet == HOLD) begin
               m_mode   = M_RUNNING;
               m_streak = 0;
               m_done   = 1'b1;
            end
         end
      end else if (m_mode == M_RUNNING) begin
         if (m_streak == 0) begin
            if (k) begin
               m_idle = 0;
            end else begin
               m_idle++;
`ifdef RST_GEN_WDT_EN
               if (m_idle == WDT) timeout = 1'b1;
`endif
            end
         end else begin
            m_idle = 0;
         end
         if (timeout) begin
            m_mode   = M_HOLDING;
            m_quiet  = 0;
            m_streak = 0;
            m_idle   = 0;
            m_flag   = 1'b1;
         end else if (p) begin
            m_streak++;
            if (m_streak == DEB + 1) m_mode = M_LATCHED;
         end else begin
            m_streak = 0;
         end
      end else begin
         m_idle = 0;
         if (!p) begin
            m_mode  = M_HOLDING;
            m_quiet = 0;
         end
      end
   endtask

   // One clock: drive inputs, step model at the edge, compare on the falling edge
   task automatic tick(input logic r, input logic b, input logic k);
      rst    = r;
      btn_in = b;
`ifdef RST_GEN_WDT_EN
      wdt_kick = k;
`endif
      @(posedge clk);
      model_edge(r, b, k);
      @(negedge clk);
      check_eq("core_rst", {31'd0, core_rst}, {31'd0, (m_mode != M_RUNNING)});
      check_eq("rst_done", {31'd0, rst_done}, {31'd0, m_done});
`ifdef RST_GEN_WDT_EN
      check_eq("wdt_flag", {31'd0, wdt_flag}, {31'd0, m_flag});
`endif
   endtask

   initial begin
      int hi_cnt;
      int done_cnt;
      int first_hi;
      int fall_at;

      // reset state
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0);
      check_eq("reset_core_rst", {31'd0, core_rst}, 32'd1);
      check_eq("reset_rst_done", {31'd0, rst_done}, 32'd0);

      // release: 4 cycles of hold (the last reset cycle plus 3), then one rst_done
      hi_cnt = 1; done_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         tick(1'b0, 1'b1, 1'b0);
         if (core_rst) hi_cnt++;
         if (rst_done) done_cnt++;
      end
      check_eq("hold_len", hi_cnt, 32'd4);
      check_eq("done_pulses", done_cnt, 32'd1);

      // short glitch is rejected
      hi_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 1'b0, 1'b1);
         if (core_rst) hi_cnt++;
      end
      for (int i = 0; i < 10; i++) begin
         tick(1'b0, 1'b1, 1'b1);
         if (core_rst) hi_cnt++;
      end
      check_eq("glitch_core", hi_cnt, 32'd0);
      check_eq("glitch_state", 32'(dut.state_r), 32'(S_RUN));

      // long press: rises SYNC+DEB edges after the first sampling edge
      first_hi = -1; hi_cnt = 0;
      for (int i = 0; i < 30; i++) begin
         tick(1'b0, 1'b0, 1'b1);
         if (core_rst) begin
            hi_cnt++;
            if (first_hi < 0) first_hi = i;
         end
      end
      check_eq("press_rise", first_hi, SYNC + DEB);
      check_eq("press_held", hi_cnt, 30 - (SYNC + DEB));

      // release, re-press after 2 cycles, release: hold restarts
      fall_at = -1; done_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1'b0, (i < 2 || i >= 5) ? 1'b1 : 1'b0, 1'b1);
         if (!core_rst && fall_at < 0) fall_at = i;
         if (rst_done) done_cnt++;
      end
      check_eq("repress_fall", fall_at, 32'd10);
      check_eq("repress_done", done_cnt, 32'd1);

      // reset asserted mid-debounce at cnt=5
      for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 1'b1);
      check_eq("deb_state", 32'(dut.state_r), 32'(S_DEBOUNCE));
      check_eq("deb_cnt", 32'(dut.cnt_r), 32'd5);
      tick(1'b1, 1'b0, 1'b1);
      check_eq("midrst_state", 32'(dut.state_r), 32'(S_HOLD));
      hi_cnt = 1;
      for (int i = 0; i < 8; i++) begin
         tick(1'b0, 1'b1, 1'b1);
         if (core_rst) hi_cnt++;
      end
      check_eq("midrst_hold", hi_cnt, 32'd4);

`ifdef RST_GEN_WDT_EN
      // watchdog: 16 unkicked cycles in S_RUN force a reset
      first_hi = -1;
      for (int i = 0; i < 20; i++) begin
         tick(1'b0, 1'b1, 1'b0);
         if (core_rst && first_hi < 0) first_hi = i;
      end
      check_eq("wdt_fire", first_hi, WDT - 1);
      check_eq("wdt_flag_set", {31'd0, wdt_flag}, 32'd1);
      for (int i = 0; i < 2; i++) tick(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0);
      hi_cnt = 0;
      for (int i = 0; i < 60; i++) begin
         tick(1'b0, 1'b1, (i % 10) == 0);
         if (core_rst) hi_cnt++;
      end
      check_eq("wdt_kicked", hi_cnt, 32'd0);
`endif

      // random traffic
      for (int seg = 0; seg < 80; seg++) begin
         int   len;
         logic lvl;
         logic do_rst;
         len    = $urandom_range(1, 14);
         lvl    = 1'($urandom_range(0, 1));
         do_rst = ($urandom_range(0, 19) == 0);
         for (int i = 0; i < len; i++) begin
            tick(do_rst && (i == 0), lvl, $urandom_range(0, 9) == 0);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
